// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: EX/MEM inputs, data-memory bus and MEM/WB result of the memory stage.
interface mem_stage_lsu_if;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [31:0] ex_alu_result;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        stall_o;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_fault_align;
  logic        wb_fault_range;
  modport master (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_unsigned, ex_addr, ex_wdata,
           ex_alu_result, ex_rd, ex_reg_write, dmem_rdata,
    output stall_o, dmem_addr, dmem_wdata, dmem_read, dmem_write,
           wb_valid, wb_reg_write, wb_rd, wb_data, wb_fault_align, wb_fault_range
  );
  modport slave (
    output ex_valid, ex_mem_read, ex_mem_write, ex_size, ex_unsigned, ex_addr, ex_wdata,
           ex_alu_result, ex_rd, ex_reg_write, dmem_rdata,
    input  stall_o, dmem_addr, dmem_wdata, dmem_read, dmem_write,
           wb_valid, wb_reg_write, wb_rd, wb_data, wb_fault_align, wb_fault_range
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MIPS memory stage; word-aligned big-endian accesses, sub-word RMW stores, registered MEM/WB result.
module mem_stage_lsu #(
  parameter int DMEM_BYTES = 32,
  parameter int MEM_LAT    = 1
) (
  input logic clk,
  input logic reset,
  mem_stage_lsu_if.master bus
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE} state_t;
  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rw;
    logic        store;
  } cap_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic        wbv;
    logic        wbrw;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        fa;
    logic        fr;
  } out_t;
  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  cap_t        cap, cap_n;
  out_t        q, d;
  logic [31:0] wa, lane_mask, raw, load_val, merged;
  logic [4:0]  lane_sh;
  logic        is_word, is_store, mem_op, fa, fr;
  assign wa       = {bus.ex_addr[31:2], 2'b00};
  assign is_word  = bus.ex_size[1];
  assign is_store = bus.ex_mem_write & ~bus.ex_mem_read;
  assign mem_op   = bus.ex_mem_read | bus.ex_mem_write;
  assign fa       = (bus.ex_size == 2'b01 & bus.ex_addr[0]) | (is_word & |bus.ex_addr[1:0]);
  assign fr       = {1'b0, wa} + 33'd4 > 33'(DMEM_BYTES);
  // byte 0 sits in [31:24], so lanes shift right by 8*(3-o) or 16*(1-o[1])
  assign lane_sh   = cap.size == 2'b00 ? {~cap.off, 3'b000} : {~cap.off[1], 4'b0000};
  assign lane_mask = (cap.size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
  assign raw       = bus.dmem_rdata >> lane_sh;
  assign load_val  = cap.size[1] ? bus.dmem_rdata :
                     cap.size[0] ? {{16{~cap.uns & raw[15]}}, raw[15:0]} :
                                   {{24{~cap.uns & raw[7]}}, raw[7:0]};
  assign merged    = (bus.dmem_rdata & ~lane_mask) | ((cap.wdata << lane_sh) & lane_mask);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_n   = cap;
    d       = q;
    d.rd    = 1'b0;
    d.wr    = 1'b0;
    d.wbv   = 1'b0;
    case (state)
      IDLE: if (bus.ex_valid) begin
        cap_n = '{size: bus.ex_size, uns: bus.ex_unsigned, off: bus.ex_addr[1:0], wdata: bus.ex_wdata,
                  rd: bus.ex_rd, rw: bus.ex_reg_write, store: is_store};
        if (!mem_op || fa || fr) begin
          d.wbv  = 1'b1;
          d.wbrd = bus.ex_rd;
          d.wbrw = mem_op ? 1'b0 : bus.ex_reg_write;
          d.wbd  = mem_op ? 32'd0 : bus.ex_alu_result;
          d.fa   = mem_op & fa;
          d.fr   = mem_op & fr;
        end else begin
          d.addr = wa;
          if (is_store && is_word) begin
            state_n = WRITE;
            d.wdata = bus.ex_wdata;
            d.wr    = 1'b1;
          end else begin
            state_n = RD_WAIT;
            cnt_n   = 3'(MEM_LAT);
            d.rd    = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) begin
          if (cap.store) begin
            state_n = WRITE;
            d.wdata = merged;
            d.wr    = 1'b1;
          end else begin
            state_n = IDLE;
            d.wbv   = 1'b1;
            d.wbrw  = cap.rw;
            d.wbrd  = cap.rd;
            d.wbd   = load_val;
            d.fa    = 1'b0;
            d.fr    = 1'b0;
          end
        end
      end
      WRITE: begin
        state_n = IDLE;
        d.wbv   = 1'b1;
        d.wbrw  = 1'b0;
        d.wbrd  = cap.rd;
        d.wbd   = 32'd0;
        d.fa    = 1'b0;
        d.fr    = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      cap   <= '0;
      q     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cap   <= cap_n;
      q     <= d;
    end
  end
  assign bus.stall_o        = state != IDLE;
  assign bus.dmem_addr      = q.addr;
  assign bus.dmem_wdata     = q.wdata;
  assign bus.dmem_read      = q.rd;
  assign bus.dmem_write     = q.wr;
  assign bus.wb_valid       = q.wbv;
  assign bus.wb_reg_write   = q.wbrw;
  assign bus.wb_rd          = q.wbrd;
  assign bus.wb_data        = q.wbd;
  assign bus.wb_fault_align = q.fa;
  assign bus.wb_fault_range = q.fr;
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage of the pipelined MIPS core. Sits between the EX/MEM pipeline register and the byte-addressed, big-endian data memory. Drives the memory's data_address, write_data, read_data, MemRead and MemWrite.
- Converts byte, half and word loads/stores into word-aligned memory transactions:
  - sub-word loads: lane extraction plus sign/zero extension;
  - sub-word stores: read-modify-write.
- Checks alignment and range.
- Produces the registered MEM/WB result and a stall back to the pipeline.

Parameters:
- DMEM_BYTES, 32: data memory size in bytes; must be a multiple of 4.
- MEM_LAT, 1: cycles from dmem_read asserted to dmem_rdata valid; range 1 to 7.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: reset, synchronous, active-low.
- ex_valid, input, 1: EX/MEM holds a valid instruction.
- ex_mem_read, input, 1: load.
- ex_mem_write, input, 1: store.
- ex_size, input, 2: access size; 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- ex_unsigned, input, 1: zero-extend loads (LBU/LHU).
- ex_addr, input, 32: byte address.
- ex_wdata, input, 32: store data, right-justified.
- ex_alu_result, input, 32: result for non-memory instructions.
- ex_rd, input, 5: destination register.
- ex_reg_write, input, 1: instruction writes rd.
- stall_o, output, 1: upstream must hold ex_* stable.
- dmem_addr, output, 32: word-aligned address to memory.
- dmem_wdata, output, 32: full word to memory.
- dmem_read, output, 1: one-cycle read strobe.
- dmem_write, output, 1: one-cycle write strobe.
- dmem_rdata, input, 32: word from memory. The byte at offset 0 occupies bits [31:24].
- wb_valid, output, 1: one-cycle result pulse.
- wb_reg_write, output, 1: register-file write enable.
- wb_rd, output, 5: destination register.
- wb_data, output, 32: writeback data.
- wb_fault_align, output, 1: misaligned access.
- wb_fault_range, output, 1: address outside memory.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state IDLE, counter 0.
  - All outputs 0.
  - Any in-flight access is aborted: no dmem strobe in the cycle after the reset edge, and the pending result is dropped.
- States: IDLE, RD_WAIT, WRITE.
- stall_o = (state != IDLE). It is purely a function of the registered state.
- Accept edge A: a rising edge with state IDLE and ex_valid=1. All ex_* fields are captured at A.
- ex_mem_read and ex_mem_write both high: treated as a load; the write is ignored.
- Word address wa = {ex_addr[31:2], 2'b00}; offset o = ex_addr[1:0].
- Faults:
  - align fault: half access with o[0]=1, or word access with o!=0.
  - range fault: wa+4 > DMEM_BYTES, computed without 32-bit overflow.
  - Each flag is independent.
- Faulting memory op:
  - No dmem strobe; state stays IDLE.
  - At A: wb_valid=1, the matching fault flag(s) set, wb_reg_write=0, wb_data=0.
- Non-memory op: at A, wb_valid=1, wb_data=ex_alu_result, wb_reg_write=ex_reg_write. Zero stall.
- Load:
  - At A: go to RD_WAIT, counter=MEM_LAT, dmem_addr=wa, dmem_read=1 for exactly one cycle.
  - Counter decrements each cycle. At the edge where counter==1, sample dmem_rdata, write the wb outputs (wb_reg_write=ex_reg_write), go to IDLE.
  - Stall lasts MEM_LAT cycles; the next accept is at edge A+MEM_LAT+1.
- Lane extraction:
  - byte: bits [31-8o -: 8].
  - half: [31:16] if o=0, [15:0] if o=2.
  - Sign-extended unless ex_unsigned.
- Word store: at A, go to WRITE with dmem_addr=wa, dmem_wdata=ex_wdata, dmem_write=1 for one cycle. On the next edge, go to IDLE with wb_valid=1 and wb_reg_write=0.
- Sub-word store (read-modify-write):
  - RD_WAIT exactly as for a load.
  - At the sample edge, merge ex_wdata[7:0] or ex_wdata[15:0] into the addressed lane(s), keeping the other bytes.
  - Go to WRITE; dmem_write=1 for one cycle with the merged word; then IDLE with wb_valid.
  - Total stall MEM_LAT+1 cycles.
- wb_valid is high for exactly one cycle per accepted instruction.
- Other wb_* fields hold their value until the next wb_valid.
- dmem_read and dmem_write are never high in the same cycle.
- ex_valid=0 in IDLE: no action, wb_valid=0.

Test Plan:
Memory initialised so that byte k = 20+k; MEM_LAT=1.
1. LW addr 4, rd=5 → dmem_read one cycle with dmem_addr=4; stall_o high for 1 cycle; wb_valid with wb_data=0x18191A1B, wb_rd=5, wb_reg_write=1.
2. LH addr 2 → wb_data=0x00001617. LBU addr 7 → wb_data=0x0000001B.
3. SB 0xF0 addr 9 → read of word 8, then dmem_write with 0x1CF01E1F; stall_o high for 2 cycles. Then LB addr 9 → 0xFFFFFFF0, and LBU addr 9 → 0x000000F0.
4. LW addr 6 → wb_fault_align=1, wb_reg_write=0, no strobe. LW addr 32 → wb_fault_range=1, no strobe.
5. Back-to-back ADD (alu_result 0x55) then SW 0x01020304 addr 12 → wb_valid pulses one cycle apart; word 12 is written as 0x01020304; a following LW addr 12 returns 0x01020304.
6. Reset asserted in the RD_WAIT cycle of an SH → no dmem_write after the reset edge, no wb_valid, stall_o=0, memory word unchanged.
